lc_otp_prog_seq: RTL and testbench



---
 rtl/lc_otp_prog_seq_pkg.sv | 45 ++++
 rtl/lc_otp_prog_seq_tx_reg.sv | 19 +
 rtl/lc_otp_prog_seq.sv | 142 ++++++++++++++
 tb/tb_lc_otp_prog_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc_otp_prog_seq_pkg.sv
// rtl/lc_otp_prog_seq_pkg.sv - shared types and constants for the LC OTP program sequencer
package lc_otp_prog_seq_pkg;

    typedef logic [3:0] lc_tx_t;
    localparam lc_tx_t On  = 4'b0101;
    localparam lc_tx_t Off = 4'b1010;

    localparam int unsigned TimeoutCyclesDefault = 1024;

    typedef enum logic [7:0] {
        LcStRaw           = 8'h00,
        LcStTestUnlocked0 = 8'h11,
        LcStDev           = 8'h5A,
        LcStProd          = 8'hA5,
        LcStRma           = 8'hC3,
        LcStScrap         = 8'hFF
    } lc_state_e;

    typedef enum logic [3:0] {
        LcCnt0  = 4'd0,  LcCnt1  = 4'd1,  LcCnt2  = 4'd2,  LcCnt3  = 4'd3,
        LcCnt4  = 4'd4,  LcCnt5  = 4'd5,  LcCnt6  = 4'd6,  LcCnt7  = 4'd7,
        LcCnt8  = 4'd8,  LcCnt9  = 4'd9,  LcCnt10 = 4'd10, LcCnt11 = 4'd11,
        LcCnt12 = 4'd12, LcCnt13 = 4'd13, LcCnt14 = 4'd14, LcCnt15 = 4'd15
    } lc_cnt_e;

    typedef struct packed {
        logic      req;
        lc_state_e state;
        lc_cnt_e   count;
    } lc_otp_program_req_t;

    typedef struct packed {
        logic err;
        logic ack;
    } lc_otp_program_rsp_t;

    // Sparse encoding: single-bit upsets cannot turn one legal state into another.
    typedef enum logic [5:0] {
        StIdle  = 6'b001011,
        StProg  = 6'b110010,
        StResp  = 6'b100101,
        StFatal = 6'b011100
    } state_e;

endpackage

// File: rtl/lc_otp_prog_seq_tx_reg.sv
// rtl/lc_otp_prog_seq_tx_reg.sv - multibit lc_tx_t register that sanitizes anything but On to Off
module lc_tx_reg
    import lc_otp_prog_seq_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [$bits(lc_tx_t)-1:0] d_i,
    output logic [$bits(lc_tx_t)-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= Off;
        end else begin
            q_o <= (d_i == On) ? On : Off;
        end
    end

endmodule

// File: rtl/lc_otp_prog_seq.sv
// rtl/lc_otp_prog_seq.sv - LC transition command to fuse_ctrl program handshake sequencer
module lc_otp_prog_seq
    import lc_otp_prog_seq_pkg::*;
#(
    parameter int unsigned TimeoutCycles = TimeoutCyclesDefault,
    parameter int unsigned CntW          = 11
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   trans_req_i,
    input  logic [$bits(lc_state_e)-1:0]           trans_state_i,
    input  logic [$bits(lc_cnt_e)-1:0]             trans_cnt_i,
    output logic                                   trans_ack_o,
    output logic                                   trans_err_o,
    input  logic                                   escalate_i,
    input  logic [$bits(lc_tx_t)-1:0]              dft_req_i,
    output logic [$bits(lc_otp_program_req_t)-1:0] lc_otp_program_o,
    input  logic [$bits(lc_otp_program_rsp_t)-1:0] lc_otp_program_rsp_i,
    output logic [$bits(lc_tx_t)-1:0]              lc_check_byp_en_o,
    output logic [$bits(lc_tx_t)-1:0]              lc_escalate_en_o,
    output logic [$bits(lc_tx_t)-1:0]              lc_dft_en_o,
    output logic                                   fatal_o
);

    state_e              state_q, state_d;
    lc_otp_program_req_t prog_q, prog_d;
    lc_otp_program_rsp_t rsp;
    logic                err_q, err_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic                terr_q, terr_d;
    logic                fatal_q;
    logic                timeout;
    logic                esc_on;
    lc_tx_t              byp_d, esc_d, dft_d;

    assign rsp     = lc_otp_program_rsp_i;
    assign timeout = (TimeoutCycles != 0) && (cnt_q == CntW'(TimeoutCycles - 1));

    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        terr_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (trans_req_i) begin
                    state_d = StProg;
                    prog_d  = '{req:   1'b1,
                                state: lc_state_e'(trans_state_i),
                                count: lc_cnt_e'(trans_cnt_i)};
                    cnt_d   = '0;
                end
            end
            StProg: begin
                cnt_d = cnt_q + CntW'(1);
                // Escalation beats everything; a coincident ack beats the timeout.
                if (escalate_i) begin
                    state_d = StFatal;
                    prog_d  = '0;
                end else if (rsp.ack) begin
                    state_d = StResp;
                    err_d   = rsp.err;
                    prog_d  = '0;
                end else if (timeout) begin
                    state_d = StFatal;
                    prog_d  = '0;
                    ack_d   = 1'b1;
                    terr_d  = 1'b1;
                end
            end
            StResp: begin
                ack_d   = 1'b1;
                terr_d  = err_q;
                state_d = err_q ? StFatal : StIdle;
            end
            StFatal: begin
                state_d = StFatal;
                prog_d  = '0;
            end
            default: begin
                state_d = StFatal;
                prog_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            prog_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            terr_q  <= 1'b0;
            fatal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            terr_q  <= terr_d;
            fatal_q <= (state_d == StFatal);
        end
    end

    // Enables are computed from the next state so they line up with the other registered outputs.
    assign esc_on = escalate_i || (state_d == StFatal);
    assign byp_d  = (state_d == StProg) ? On : Off;
    assign esc_d  = esc_on ? On : Off;
    assign dft_d  = esc_on ? Off : lc_tx_t'(dft_req_i);

    lc_tx_reg u_check_byp_en (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (byp_d),
        .q_o   (lc_check_byp_en_o)
    );

    lc_tx_reg u_escalate_en (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (esc_d),
        .q_o   (lc_escalate_en_o)
    );

    lc_tx_reg u_dft_en (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (dft_d),
        .q_o   (lc_dft_en_o)
    );

    assign lc_otp_program_o = prog_q;
    assign trans_ack_o      = ack_q;
    assign trans_err_o      = terr_q;
    assign fatal_o          = fatal_q;

endmodule

// File: tb/tb_lc_otp_prog_seq.sv
// tb/tb_lc_otp_prog_seq.sv - scoreboard bench for lc_otp_prog_seq
module tb_lc_otp_prog_seq;

    localparam logic [3:0] ON  = 4'b0101;
    localparam logic [3:0] OFF = 4'b1010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trans_req = 1'b0;
    logic [7:0]  trans_state = 8'h00;
    logic [3:0]  trans_cnt = 4'h0;
    logic        trans_ack, trans_err;
    logic        escalate = 1'b0;
    logic [3:0]  dft_req = OFF;
    logic [12:0] prog;
    logic [1:0]  rsp = 2'b00;
    logic [3:0]  byp, esc, dft;
    logic        fatal;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cmd_cyc = 0;

    typedef struct {
        logic err;
        int   cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lc_otp_prog_seq #(
        .TimeoutCycles (8),
        .CntW          (4)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .trans_req_i          (trans_req),
        .trans_state_i        (trans_state),
        .trans_cnt_i          (trans_cnt),
        .trans_ack_o          (trans_ack),
        .trans_err_o          (trans_err),
        .escalate_i           (escalate),
        .dft_req_i            (dft_req),
        .lc_otp_program_o     (prog),
        .lc_otp_program_rsp_i (rsp),
        .lc_check_byp_en_o    (byp),
        .lc_escalate_en_o     (esc),
        .lc_dft_en_o          (dft),
        .fatal_o              (fatal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every trans_ack_o must match the oldest expected completion.
    always @(negedge clk) begin
        if (!rst && trans_ack) begin
            check("ack_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ack_err", 32'(trans_err), 32'(e.err));
                check("ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic err, input int at);
        exp_t x;
        x.err = err;
        x.cyc = at;
        exp_q.push_back(x);
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        trans_req = 1'b0;
        rsp       = 2'b00;
        escalate  = 1'b0;
        dft_req   = OFF;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_cmd(input logic [7:0] s, input logic [3:0] c);
        trans_req    = 1'b1;
        trans_state  = s;
        trans_cnt    = c;
        last_cmd_cyc = cyc;
        tick();
        trans_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        // Reset values
        #12;
        check("rst_prog", 32'(prog), 32'h0);
        check("rst_byp", 32'(byp), 32'(OFF));
        check("rst_esc", 32'(esc), 32'(OFF));
        check("rst_dft", 32'(dft), 32'(OFF));
        check("rst_ack", 32'({trans_ack, trans_err}), 32'h0);
        check("rst_fatal", 32'(fatal), 32'h0);

        // 1: normal transition, ack three cycles after req rises
        do_reset();
        start_cmd(8'h11, 4'h3);
        for (int i = 0; i < 3; i++) begin
            check("t1_req", 32'(prog), 32'h1113);
            check("t1_byp", 32'(byp), 32'(ON));
            tick();
        end
        rsp = 2'b01;
        check("t1_req_at_ack", 32'(prog), 32'h1113);
        push_exp(1'b0, cyc + 2);
        tick();
        rsp = 2'b00;
        check("t1_req_drop", 32'(prog), 32'h0);
        check("t1_byp_off", 32'(byp), 32'(OFF));
        repeat (3) tick();
        check("t1_fatal", 32'(fatal), 32'h0);

        // ack outside PROG is ignored
        rsp = 2'b11;
        tick();
        rsp = 2'b00;
        repeat (3) tick();
        check("stray_ack_req", 32'(prog), 32'h0);
        check("stray_ack_fatal", 32'(fatal), 32'h0);

        // 2: ack with err=1 leads to sticky FATAL
        start_cmd(8'h5A, 4'h4);
        tick();
        rsp = 2'b11;
        push_exp(1'b1, cyc + 2);
        tick();
        rsp = 2'b00;
        repeat (2) tick();
        check("t2_fatal", 32'(fatal), 32'h1);
        check("t2_esc", 32'(esc), 32'(ON));
        trans_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_no_req", 32'(prog), 32'h0);
        end
        trans_req = 1'b0;
        check("t2_fatal_sticky", 32'(fatal), 32'h1);
        check("t2_esc_sticky", 32'(esc), 32'(ON));

        // 3a: watchdog timeout after 8 cycles of req
        do_reset();
        start_cmd(8'hA5, 4'h5);
        for (int i = 0; i < 8; i++) begin
            check("t3_req_held", 32'(prog[12]), 32'h1);
            if (i == 7) push_exp(1'b1, cyc + 1);
            tick();
        end
        check("t3_req_drop", 32'(prog), 32'h0);
        check("t3_fatal", 32'(fatal), 32'h1);
        repeat (3) tick();

        // 3b: ack on the 8th cycle wins over the timeout
        do_reset();
        start_cmd(8'hA5, 4'h5);
        repeat (7) tick();
        check("t3b_req_held", 32'(prog[12]), 32'h1);
        rsp = 2'b01;
        push_exp(1'b0, cyc + 2);
        tick();
        rsp = 2'b00;
        repeat (3) tick();
        check("t3b_fatal", 32'(fatal), 32'h0);

        // 4: escalation during PROG
        do_reset();
        dft_req = ON;
        tick();
        check("t4_dft_on", 32'(dft), 32'(ON));
        start_cmd(8'h11, 4'h2);
        check("t4_req", 32'(prog[12]), 32'h1);
        escalate = 1'b1;
        tick();
        escalate = 1'b0;
        check("t4_req_drop", 32'(prog), 32'h0);
        check("t4_fatal", 32'(fatal), 32'h1);
        check("t4_esc", 32'(esc), 32'(ON));
        check("t4_dft_off", 32'(dft), 32'(OFF));
        repeat (3) tick();
        check("t4_esc_sticky", 32'(esc), 32'(ON));
        check("t4_dft_still_off", 32'(dft), 32'(OFF));

        // 5: DFT enable sanitizing and escalation override outside FATAL
        do_reset();
        dft_req = ON;
        tick();
        check("t5_dft_on", 32'(dft), 32'(ON));
        dft_req = 4'b0110;
        tick();
        check("t5_dft_bad", 32'(dft), 32'(OFF));
        dft_req = OFF;
        tick();
        check("t5_dft_off", 32'(dft), 32'(OFF));
        dft_req  = ON;
        escalate = 1'b1;
        tick();
        check("t5_esc_idle", 32'(esc), 32'(ON));
        check("t5_dft_forced", 32'(dft), 32'(OFF));
        escalate = 1'b0;
        tick();
        check("t5_esc_release", 32'(esc), 32'(OFF));
        check("t5_dft_back", 32'(dft), 32'(ON));
        check("t5_fatal", 32'(fatal), 32'h0);

        // 6: reset mid-PROG, then a minimum-latency transition
        do_reset();
        start_cmd(8'hC3, 4'h6);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6_prog", 32'(prog), 32'h0);
        check("t6_byp", 32'(byp), 32'(OFF));
        check("t6_ack", 32'({trans_ack, trans_err}), 32'h0);
        check("t6_fatal", 32'(fatal), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        start_cmd(8'h11, 4'h7);
        check("t6_new_req", 32'(prog), 32'h1117);
        tick();
        rsp = 2'b01;
        push_exp(1'b0, last_cmd_cyc + 4);
        tick();
        rsp = 2'b00;
        repeat (4) tick();
        check("t6_fatal_after", 32'(fatal), 32'h0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
